// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch controller states (IDLE, RUN, REDIR)
//   PC_W_DEF      : default program-counter / instruction-address width
//   INST_W_DEF    : default instruction width
//   OP_HALT       : halt/NOP opcode, reserved for decode (fetch never inspects it)
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned PC_W_DEF   = 6;
  localparam int unsigned INST_W_DEF = 16;

  localparam logic [3:0] OP_HALT = 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Bundles every non-clock signal of the fetch stage: the instruction-memory
// read port, the decode-side valid/ready handshake and the branch redirect.
//   master : the fetch unit's view (drives imem_req/imem_addr and the if_* head)
//   slave  : the environment's view (memory, decode and EX/MEM redirect source)
// Signals:
//   imem_req      fetch -> mem     read request this cycle
//   imem_addr     fetch -> mem     read address (registered fetch PC)
//   imem_rdata    mem   -> fetch   read data, one cycle after an accepted request
//   if_valid      fetch -> decode  queue head holds a valid instruction
//   if_inst       fetch -> decode  queue head instruction
//   if_pc         fetch -> decode  queue head address + 1
//   id_ready      decode -> fetch  decode consumes the head this cycle
//   branch_taken  EX/MEM -> fetch  redirect request
//   branch_target EX/MEM -> fetch  redirect address
// -----------------------------------------------------------------------------
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) ();

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;

  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0]   if_pc;
  logic              id_ready;

  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;

  modport master (
    output imem_req, imem_addr, if_valid, if_inst, if_pc,
    input  imem_rdata, id_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_inst, if_pc,
    output imem_rdata, id_ready, branch_taken, branch_target
  );

endinterface : fetch_if

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous prefetch queue with push, pop and flush.
// Flush dominates push and pop. When the queue is empty the data output keeps
// showing the last entry that left the head, so downstream never sees stale
// slot contents.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_push   in   write i_data at the tail (must not be asserted when full)
//   i_pop    in   drop the head (ignored when empty)
//   i_flush  in   discard all entries
//   i_data   in   WIDTH-bit entry to push
//   o_data   out  head entry (or last departed head when empty)
//   o_count  out  number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int WIDTH = 22,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_last;

  logic w_do_push;
  logic w_do_pop;
  logic w_empty;

  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~i_flush & ~w_empty;

  // NOTE: storage has no reset; a slot is only ever read after being written,
  // and the empty-queue output comes from r_last, which is reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // The flushed head was on the output; keep it there while empty.
      if (!w_empty) begin
        r_last <= r_mem[r_rd_ptr];
      end
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = w_empty ? r_last : r_mem[r_rd_ptr];
  assign o_count = r_count;

  // The producer's credit check must keep pushes away from a full queue.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n)
      !(i_push && !i_flush && (r_count == CNT_W'(DEPTH)))
  );

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the 16-bit pipelined core. Owns the program
// counter, drives a 1-cycle-latency synchronous instruction memory, buffers
// returned words in a DEPTH-entry prefetch queue and hands them to decode over
// a valid/ready handshake. A branch redirect from EX/MEM flushes the queue and
// any in-flight read and restarts fetch at the target.
// Optional build macro:
//   FETCH_STATS_EN : adds saturating 16-bit stat_fetched (pushes) and
//                    stat_flushes (redirect cycles) outputs.
// Ports:
//   clk           in   clock, rising edge
//   clear         in   asynchronous active-low reset
//   bus           --   fetch_if.master (imem_*, if_*, id_ready, branch_*)
//   stat_fetched  out  [FETCH_STATS_EN] number of instructions queued
//   stat_flushes  out  [FETCH_STATS_EN] number of redirect cycles
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        clear,
  fetch_if.master     bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] stat_fetched,
  output logic [15:0] stat_flushes
`endif
);

  localparam int ENTRY_W = PC_W + INST_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_req_pc;
  logic               r_inflight;

  logic               w_req;
  logic               w_credit_ok;
  logic               w_push;
  logic               w_pop;
  logic               w_if_valid;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;

  // Credit counts queued plus in-flight words and deliberately ignores this
  // cycle's pop, so id_ready never reaches imem_req combinationally.
  assign w_credit_ok = (int'(w_count) + int'(r_inflight)) < DEPTH;

  // ---------------------------------------------------------------------------
  // Controller: state register + next-state/request decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = RUN;
      end
      RUN, REDIR: begin
        // REDIR is a one-cycle marker after a redirect; it fetches like RUN.
        w_state_next = RUN;
        w_req        = ~bus.branch_taken & w_credit_ok;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // A redirect overrides whatever the state would otherwise do.
    if (bus.branch_taken) begin
      w_state_next = REDIR;
    end
  end

  // ---------------------------------------------------------------------------
  // Program counter and in-flight tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_pc       <= '0;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else if (bus.branch_taken) begin
      r_pc       <= bus.branch_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc     <= r_pc + PC_W'(1);
        r_req_pc <= r_pc;
      end
    end
  end

  // A response is dropped if a redirect lands in its response cycle; a
  // redirect in the request cycle already blocked the request itself.
  assign w_push      = r_inflight & ~bus.branch_taken;
  assign w_pop       = w_if_valid & bus.id_ready & ~bus.branch_taken;
  assign w_push_data = {r_req_pc + PC_W'(1), bus.imem_rdata};

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.branch_taken),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign w_if_valid    = (w_count != '0);

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = w_if_valid;
  assign bus.if_inst   = w_head[INST_W-1:0];
  assign bus.if_pc     = w_head[ENTRY_W-1:INST_W];

`ifdef FETCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating activity counters
  // ---------------------------------------------------------------------------
  logic [15:0] r_stat_fetched;
  logic [15:0] r_stat_flushes;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_stat_fetched <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (w_push && (r_stat_fetched != 16'hFFFF)) begin
        r_stat_fetched <= r_stat_fetched + 16'd1;
      end
      if (bus.branch_taken && (r_stat_flushes != 16'hFFFF)) begin
        r_stat_flushes <= r_stat_flushes + 16'd1;
      end
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushes = r_stat_flushes;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed self-checking bench for fetch_unit. A behavioural 1-cycle-latency
// memory returns mem[k] = 16'h1000 + k. Inputs change 1 time unit after the
// rising edge; outputs are compared 2 time units after it.
// Builds with or without FETCH_STATS_EN.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PC_W   = 6;
  localparam int INST_W = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic clear;

  int n_checks = 0;
  int n_errors = 0;

  logic [INST_W-1:0] mem [2**PC_W];

  fetch_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_flushes;
`endif

  fetch_unit #(
    .PC_W   (PC_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .bus          (bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_flushes (stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge clk) begin
    if (bus.imem_req) begin
      bus.imem_rdata <= mem[bus.imem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, apply this cycle's inputs, let combinational paths settle.
  task automatic step(input logic br, input logic [PC_W-1:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.id_ready      = rdy;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(bus.imem_req),  0);
    check({tag, "_addr"},  32'(bus.imem_addr), 0);
    check({tag, "_valid"}, 32'(bus.if_valid),  0);
    check({tag, "_inst"},  32'(bus.if_inst),   0);
    check({tag, "_pc"},    32'(bus.if_pc),     0);
  endtask

  initial begin
    for (int k = 0; k < 2**PC_W; k++) begin
      mem[k] = 16'h1000 + 16'(k);
    end
    clear             = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.id_ready      = 1'b1;

    // ---- reset state --------------------------------------------------------
    #12;
    check_all_zero("reset");

    // ---- reset release, streaming with id_ready=1 ---------------------------
    clear = 1'b1;
    #1;
    check("idle_req", 32'(bus.imem_req), 0);
    step(1'b0, '0, 1'b1);                       // RUN cycle 0
    check("run0_req",  32'(bus.imem_req),  1);
    check("run0_addr", 32'(bus.imem_addr), 0);
    step(1'b0, '0, 1'b1);                       // RUN cycle 1
    check("run1_addr",  32'(bus.imem_addr), 1);
    check("run1_valid", 32'(bus.if_valid),  0);
    for (int k = 0; k < 3; k++) begin           // RUN cycles 2..4
      step(1'b0, '0, 1'b1);
      check("stream_valid", 32'(bus.if_valid), 1);
      check("stream_inst",  32'(bus.if_inst),  32'h1000 + k);
      check("stream_pc",    32'(bus.if_pc),    k + 1);
    end

    // ---- asynchronous clear mid-stream --------------------------------------
    #2;
    clear = 1'b0;
    #1;
    check_all_zero("clear");
`ifdef FETCH_STATS_EN
    check("clear_stat_fetched", 32'(stat_fetched), 0);
    check("clear_stat_flushes", 32'(stat_flushes), 0);
`endif

    // ---- backpressure from reset: exactly DEPTH fetches ---------------------
    bus.id_ready = 1'b0;
    step(1'b0, '0, 1'b0);
    clear = 1'b1;
    #1;
    check("bp_idle_req", 32'(bus.imem_req), 0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b0);
      check("bp_req",  32'(bus.imem_req),  1);
      check("bp_addr", 32'(bus.imem_addr), k);
    end
    step(1'b0, '0, 1'b0);
    check("bp_stop_req", 32'(bus.imem_req), 0);
    step(1'b0, '0, 1'b0);
    check("full_req",   32'(bus.imem_req),  0);
    check("full_pc",    32'(bus.imem_addr), 4);
    check("full_valid", 32'(bus.if_valid),  1);
    check("full_inst",  32'(bus.if_inst),   32'h1000);
    check("full_ifpc",  32'(bus.if_pc),     1);
`ifdef FETCH_STATS_EN
    check("full_stat_fetched", 32'(stat_fetched), 4);
`endif

    // ---- drain: consecutive, no gaps or duplicates --------------------------
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b1);
      check("drain_valid", 32'(bus.if_valid), 1);
      check("drain_inst",  32'(bus.if_inst),  32'h1000 + k);
    end

    // ---- refill, then redirect while full -----------------------------------
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, 1'b0);
    end
    check("refill_req",   32'(bus.imem_req), 0);
    check("refill_valid", 32'(bus.if_valid), 1);
    step(1'b1, 6'h10, 1'b1);                    // redirect cycle t
    check("redir_req", 32'(bus.imem_req), 0);
    step(1'b0, '0, 1'b1);                       // t+1
    check("redir1_req",   32'(bus.imem_req),  1);
    check("redir1_addr",  32'(bus.imem_addr), 32'h10);
    check("redir1_valid", 32'(bus.if_valid),  0);
    step(1'b0, '0, 1'b1);                       // t+2: response in flight
    check("redir2_valid", 32'(bus.if_valid), 0);
    step(1'b0, '0, 1'b1);                       // t+3: target at head
    check("redir3_valid", 32'(bus.if_valid), 1);
    check("redir3_inst",  32'(bus.if_inst),  32'h1010);
    check("redir3_pc",    32'(bus.if_pc),    32'h11);

    // ---- redirect with a response in flight and id_ready=1 ------------------
    step(1'b1, 6'h20, 1'b1);                    // head 1011 shown, not consumed
    check("sq_head", 32'(bus.if_inst),  32'h1011);
    check("sq_req",  32'(bus.imem_req), 0);
    step(1'b0, '0, 1'b1);
    check("sq1_valid", 32'(bus.if_valid),  0);
    check("sq1_addr",  32'(bus.imem_addr), 32'h20);
    step(1'b0, '0, 1'b1);
    check("sq2_valid", 32'(bus.if_valid), 0);
    step(1'b0, '0, 1'b1);
    check("sq3_inst", 32'(bus.if_inst), 32'h1020);
    check("sq3_pc",   32'(bus.if_pc),   32'h21);
    step(1'b0, '0, 1'b1);
    check("sq4_inst", 32'(bus.if_inst), 32'h1021);

    // ---- back-to-back redirects (last wins) and PC wrap ---------------------
    step(1'b1, 6'h05, 1'b1);
    step(1'b1, 6'd62, 1'b1);                    // lands in the REDIR cycle
    check("b2b_req", 32'(bus.imem_req), 0);
    step(1'b0, '0, 1'b1);
    check("wrap_req",   32'(bus.imem_req),  1);
    check("wrap_addr0", 32'(bus.imem_addr), 62);
    step(1'b0, '0, 1'b1);
    check("wrap_addr1", 32'(bus.imem_addr), 63);
    step(1'b0, '0, 1'b1);
    check("wrap_addr2", 32'(bus.imem_addr), 0);
    check("wrap_pc0",   32'(bus.if_pc),     63);
    check("wrap_inst0", 32'(bus.if_inst),   32'h103E);
    step(1'b0, '0, 1'b1);
    check("wrap_pc1",   32'(bus.if_pc),     0);
    check("wrap_inst1", 32'(bus.if_inst),   32'h103F);
    step(1'b0, '0, 1'b1);
    check("wrap_pc2",   32'(bus.if_pc),     1);
    check("wrap_inst2", 32'(bus.if_inst),   32'h1000);
`ifdef FETCH_STATS_EN
    check("end_stat_flushes", 32'(stat_flushes), 4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit
